// File: rtl/rs232_frame_dec.sv
// Frame decoder behind the RS-232 receiver: assembles SYNC/CMD/DATA_H/DATA_L/CHK
// frames and reports a validated command/argument or a single error pulse.
module rs232_frame_dec #(
    parameter logic [7:0]           SyncByte   = 8'hA5,
    parameter int unsigned          ToutWidth  = 16,
    parameter logic [ToutWidth-1:0] ToutCycles = ToutWidth'(50000)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  din_i,
    input  logic        eor_i,
    input  logic        pcheck_i,
    output logic [7:0]  cmd_o,
    output logic [15:0] data_o,
    output logic        valid_o,
    output logic        err_chk_o,
    output logic        err_par_o,
    output logic        err_tout_o,
    output logic        busy_o
);

    localparam logic [ToutWidth-1:0] ToutLast = ToutCycles - ToutWidth'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DH,
        S_DL,
        S_CHK
    } state_t;

    state_t               state_q, state_d;
    logic                 eor_q;
    logic [ToutWidth-1:0] tout_q, tout_d;
    logic [7:0]           cmd_r, cmd_d;
    logic [7:0]           dh_r, dh_d;
    logic [7:0]           dl_r, dl_d;
    logic [7:0]           chk_r, chk_d;
    logic [7:0]           cmd_o_d;
    logic [15:0]          data_o_d;
    logic                 valid_d, err_chk_d, err_par_d, err_tout_d, busy_d;
    logic                 stb;

    // A held eor_i level yields exactly one byte strobe.
    assign stb = eor_i & ~eor_q;

    // Next-state, datapath and pulse decode.
    always_comb begin
        state_d    = state_q;
        tout_d     = tout_q;
        cmd_d      = cmd_r;
        dh_d       = dh_r;
        dl_d       = dl_r;
        chk_d      = chk_r;
        cmd_o_d    = cmd_o;
        data_o_d   = data_o;
        valid_d    = 1'b0;
        err_chk_d  = 1'b0;
        err_par_d  = 1'b0;
        err_tout_d = 1'b0;

        if (state_q == S_IDLE || stb) begin
            tout_d = '0;
        end else begin
            tout_d = tout_q + ToutWidth'(1);
        end

        if (state_q == S_IDLE) begin
            if (stb && din_i == SyncByte && !pcheck_i) begin
                state_d = S_CMD;
            end
        end else if (stb && pcheck_i) begin
            // Parity beats checksum evaluation, including in S_CHK.
            err_par_d = 1'b1;
            state_d   = S_IDLE;
        end else if (stb) begin
            case (state_q)
                S_CMD: begin
                    cmd_d   = din_i;
                    chk_d   = din_i;
                    state_d = S_DH;
                end
                S_DH: begin
                    dh_d    = din_i;
                    chk_d   = chk_r ^ din_i;
                    state_d = S_DL;
                end
                S_DL: begin
                    dl_d    = din_i;
                    chk_d   = chk_r ^ din_i;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    if (din_i == chk_r) begin
                        valid_d  = 1'b1;
                        cmd_o_d  = cmd_r;
                        data_o_d = {dh_r, dl_r};
                    end else begin
                        err_chk_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tout_q == ToutLast) begin
            err_tout_d = 1'b1;
            state_d    = S_IDLE;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            eor_q      <= 1'b0;
            tout_q     <= '0;
            cmd_r      <= '0;
            dh_r       <= '0;
            dl_r       <= '0;
            chk_r      <= '0;
            cmd_o      <= '0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            err_chk_o  <= 1'b0;
            err_par_o  <= 1'b0;
            err_tout_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            eor_q      <= eor_i;
            tout_q     <= tout_d;
            cmd_r      <= cmd_d;
            dh_r       <= dh_d;
            dl_r       <= dl_d;
            chk_r      <= chk_d;
            cmd_o      <= cmd_o_d;
            data_o     <= data_o_d;
            valid_o    <= valid_d;
            err_chk_o  <= err_chk_d;
            err_par_o  <= err_par_d;
            err_tout_o <= err_tout_d;
            busy_o     <= busy_d;
        end
    end

endmodule
